// File: rtl/bridge_arbiter.sv
// Round-robin arbiter that lets NUM_MASTERS requesters share one target port,
// keeping at most one transaction outstanding; every output is registered.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | sample m_req, pick winner from priority pointer, load target
//   ISSUE | t_wr or t_rd strobe high for exactly one cycle
//   WAIT  | count down read latency, capture t_rd_data at terminal count
//   DONE  | m_ack pulse to winner, advance priority pointer
module bridge_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int RD_LATENCY  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [NUM_MASTERS-1:0]    m_wr,
    input  logic [NUM_MASTERS*32-1:0] m_addr,
    input  logic [NUM_MASTERS*32-1:0] m_wr_data,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic [31:0]               m_rd_data,
    output logic [31:0]               t_addr,
    output logic [31:0]               t_wr_data,
    output logic                      t_wr,
    output logic                      t_rd,
    input  logic [31:0]               t_rd_data
);

    localparam int               IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [3:0]       CNT_LOAD = 4'(RD_LATENCY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       w_ptr_nxt;
    logic [IDX_W-1:0]       r_win;
    logic [IDX_W-1:0]       w_win_nxt;
    logic                   r_is_wr;
    logic                   w_is_wr_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic [NUM_MASTERS-1:0] r_ack;
    logic [NUM_MASTERS-1:0] w_ack_nxt;
    logic [31:0]            r_rd_data;
    logic [31:0]            w_rd_data_nxt;
    logic [31:0]            r_t_addr;
    logic [31:0]            w_t_addr_nxt;
    logic [31:0]            r_t_wr_data;
    logic [31:0]            w_t_wr_data_nxt;
    logic                   r_t_wr;
    logic                   w_t_wr_nxt;
    logic                   r_t_rd;
    logic                   w_t_rd_nxt;

    logic                   w_found;
    logic [IDX_W-1:0]       w_pick;
    logic [NUM_MASTERS-1:0] w_win_onehot;

    // First requester at or above the pointer, wrapping past the last master.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!w_found && m_req[(int'(r_ptr) + k) % NUM_MASTERS]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'((int'(r_ptr) + k) % NUM_MASTERS);
            end
        end
    end

    assign w_win_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << r_win;

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_win_nxt       = r_win;
        w_is_wr_nxt     = r_is_wr;
        w_cnt_nxt       = r_cnt;
        w_ack_nxt       = '0;
        w_rd_data_nxt   = r_rd_data;
        w_t_addr_nxt    = r_t_addr;
        w_t_wr_data_nxt = r_t_wr_data;
        w_t_wr_nxt      = 1'b0;
        w_t_rd_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt     = ISSUE;
                    w_win_nxt       = w_pick;
                    w_is_wr_nxt     = m_wr[w_pick];
                    w_t_addr_nxt    = m_addr[int'(w_pick)*32 +: 32];
                    w_t_wr_data_nxt = m_wr_data[int'(w_pick)*32 +: 32];
                    w_t_wr_nxt      = m_wr[w_pick];
                    w_t_rd_nxt      = !m_wr[w_pick];
                end
            end
            ISSUE: begin
                if (r_is_wr) begin
                    w_state_nxt = DONE;
                    w_ack_nxt   = w_win_onehot;
                end else begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            WAIT: begin
                // Terminal count lands on the edge ending cycle ISSUE+RD_LATENCY.
                if (r_cnt == 4'd0) begin
                    w_state_nxt   = DONE;
                    w_rd_data_nxt = t_rd_data;
                    w_ack_nxt     = w_win_onehot;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = (r_win == LAST_IDX) ? '0 : r_win + IDX_W'(1);
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_win       <= '0;
            r_is_wr     <= 1'b0;
            r_cnt       <= 4'd0;
            r_ack       <= '0;
            r_rd_data   <= 32'd0;
            r_t_addr    <= 32'd0;
            r_t_wr_data <= 32'd0;
            r_t_wr      <= 1'b0;
            r_t_rd      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_win       <= w_win_nxt;
            r_is_wr     <= w_is_wr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ack       <= w_ack_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_t_addr    <= w_t_addr_nxt;
            r_t_wr_data <= w_t_wr_data_nxt;
            r_t_wr      <= w_t_wr_nxt;
            r_t_rd      <= w_t_rd_nxt;
        end
    end

    assign m_ack     = r_ack;
    assign m_rd_data = r_rd_data;
    assign t_addr    = r_t_addr;
    assign t_wr_data = r_t_wr_data;
    assign t_wr      = r_t_wr;
    assign t_rd      = r_t_rd;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed bench for bridge_arbiter: four instances (2/4 masters, read latency 1/2/15),
// each with a target model that presents good data only in the exact valid cycle.
module tb_bridge_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // instance a: 2 masters, latency 2
    logic [1:0]  a_req = '0, a_wr = '0, a_ack;
    logic [63:0] a_addr = '0, a_wdata = '0;
    logic [31:0] a_rdata, a_taddr, a_twdata, a_trdata, a_rd_val = '0;
    logic        a_twr, a_trd;
    logic [15:0] a_pipe = '0;
    // instance b: 4 masters, latency 2, writes only
    logic [3:0]   b_req = '0, b_wr = '0, b_ack;
    logic [127:0] b_addr = '0, b_wdata = '0;
    logic [31:0]  b_rdata, b_taddr, b_twdata;
    logic         b_twr, b_trd;
    // instance c: 2 masters, latency 1
    logic [1:0]  c_req = '0, c_wr = '0, c_ack;
    logic [63:0] c_addr = '0, c_wdata = '0;
    logic [31:0] c_rdata, c_taddr, c_twdata, c_trdata, c_rd_val = '0;
    logic        c_twr, c_trd;
    logic [15:0] c_pipe = '0;
    // instance d: 2 masters, latency 15
    logic [1:0]  d_req = '0, d_wr = '0, d_ack;
    logic [63:0] d_addr = '0, d_wdata = '0;
    logic [31:0] d_rdata, d_taddr, d_twdata, d_trdata, d_rd_val = '0;
    logic        d_twr, d_trd;
    logic [15:0] d_pipe = '0;

    always @(posedge clk) begin
        a_pipe <= {a_pipe[14:0], a_trd};
        c_pipe <= {c_pipe[14:0], c_trd};
        d_pipe <= {d_pipe[14:0], d_trd};
    end
    assign a_trdata = a_pipe[1]  ? a_rd_val : 32'hBAD0_000A;
    assign c_trdata = c_pipe[0]  ? c_rd_val : 32'hBAD0_000C;
    assign d_trdata = d_pipe[14] ? d_rd_val : 32'hBAD0_000D;

    bridge_arbiter #(.NUM_MASTERS(2), .RD_LATENCY(2)) u_a (
        .clk(clk), .reset(reset), .m_req(a_req), .m_wr(a_wr), .m_addr(a_addr),
        .m_wr_data(a_wdata), .m_ack(a_ack), .m_rd_data(a_rdata), .t_addr(a_taddr),
        .t_wr_data(a_twdata), .t_wr(a_twr), .t_rd(a_trd), .t_rd_data(a_trdata));
    bridge_arbiter #(.NUM_MASTERS(4), .RD_LATENCY(2)) u_b (
        .clk(clk), .reset(reset), .m_req(b_req), .m_wr(b_wr), .m_addr(b_addr),
        .m_wr_data(b_wdata), .m_ack(b_ack), .m_rd_data(b_rdata), .t_addr(b_taddr),
        .t_wr_data(b_twdata), .t_wr(b_twr), .t_rd(b_trd), .t_rd_data(32'hBAD0_000B));
    bridge_arbiter #(.NUM_MASTERS(2), .RD_LATENCY(1)) u_c (
        .clk(clk), .reset(reset), .m_req(c_req), .m_wr(c_wr), .m_addr(c_addr),
        .m_wr_data(c_wdata), .m_ack(c_ack), .m_rd_data(c_rdata), .t_addr(c_taddr),
        .t_wr_data(c_twdata), .t_wr(c_twr), .t_rd(c_trd), .t_rd_data(c_trdata));
    bridge_arbiter #(.NUM_MASTERS(2), .RD_LATENCY(15)) u_d (
        .clk(clk), .reset(reset), .m_req(d_req), .m_wr(d_wr), .m_addr(d_addr),
        .m_wr_data(d_wdata), .m_ack(d_ack), .m_rd_data(d_rdata), .t_addr(d_taddr),
        .t_wr_data(d_twdata), .t_wr(d_twr), .t_rd(d_trd), .t_rd_data(d_trdata));

    task automatic test_reset();
        a_req = 2'b11;
        a_wr  = 2'b01;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_ack, a_twr, a_trd} !== 4'b0) begin
            failures++;
            $display("FAIL reset_a_ctl got=%b exp=0000", {a_ack, a_twr, a_trd});
        end
        checks++;
        if ({a_rdata, a_taddr, a_twdata} !== 96'd0) begin
            failures++;
            $display("FAIL reset_a_data got=%h exp=0", {a_rdata, a_taddr, a_twdata});
        end
        checks++;
        if ({b_ack, b_twr, b_trd, c_ack, d_ack} !== 10'd0) begin
            failures++;
            $display("FAIL reset_bcd_ctl got=%b exp=0", {b_ack, b_twr, b_trd, c_ack, d_ack});
        end
        a_req = 2'b00;
        a_wr  = 2'b00;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        @(negedge clk);
        a_req = 2'b10;
        a_wr  = 2'b10;
        a_addr[63:32]  = 32'h0000_0010;
        a_wdata[63:32] = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (a_twr !== (c == 1) || a_trd !== 1'b0) begin
                failures++;
                $display("FAIL wr_strobe c%0d got twr=%b trd=%b exp twr=%b trd=0", c, a_twr, a_trd, c == 1);
            end
            checks++;
            if (a_ack !== ((c == 2) ? 2'b10 : 2'b00)) begin
                failures++;
                $display("FAIL wr_ack c%0d got=%b exp=%b", c, a_ack, (c == 2) ? 2'b10 : 2'b00);
            end
            checks++;
            if (a_taddr !== 32'h0000_0010 || a_twdata !== 32'hDEAD_BEEF) begin
                failures++;
                $display("FAIL wr_target c%0d got=%h/%h exp=00000010/deadbeef", c, a_taddr, a_twdata);
            end
            if (c == 2) a_req = 2'b00;
        end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        a_req = 2'b01;
        a_wr  = 2'b00;
        a_addr[31:0] = 32'h0000_0004;
        a_rd_val = 32'h1234_5678;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (a_trd !== (c == 1) || a_twr !== 1'b0) begin
                failures++;
                $display("FAIL rd_strobe c%0d got trd=%b twr=%b exp trd=%b twr=0", c, a_trd, a_twr, c == 1);
            end
            checks++;
            if (a_ack !== ((c == 4) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL rd_ack c%0d got=%b exp=%b", c, a_ack, (c == 4) ? 2'b01 : 2'b00);
            end
            checks++;
            if (a_rdata !== ((c >= 4) ? 32'h1234_5678 : 32'd0)) begin
                failures++;
                $display("FAIL rd_data c%0d got=%h exp=%h", c, a_rdata, (c >= 4) ? 32'h1234_5678 : 32'd0);
            end
            if (c == 1 && a_taddr !== 32'h0000_0004) begin
                failures++;
                $display("FAIL rd_addr got=%h exp=00000004", a_taddr);
            end
            if (c == 4) a_req = 2'b00;
        end
        checks++;
    endtask

    task automatic test_contention();
        logic [3:0] e;
        @(negedge clk);
        b_req   = 4'hF;
        b_wr    = 4'hF;
        b_addr  = {32'h103, 32'h102, 32'h101, 32'h100};
        b_wdata = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            e = (c % 3 == 2 && c <= 14) ? (4'b0001 << (((c - 2) / 3) % 4)) : 4'b0000;
            checks++;
            if (b_ack !== e || !$onehot0(b_ack)) begin
                failures++;
                $display("FAIL rr_ack c%0d got=%b exp=%b", c, b_ack, e);
            end
            checks++;
            if (b_twr !== (c % 3 == 1 && c <= 13) || b_trd !== 1'b0) begin
                failures++;
                $display("FAIL rr_strobe c%0d got twr=%b trd=%b", c, b_twr, b_trd);
            end
            if (c % 3 == 1 && c <= 13) begin
                checks++;
                if (b_taddr !== 32'h100 + 32'(((c - 1) / 3) % 4)) begin
                    failures++;
                    $display("FAIL rr_addr c%0d got=%h exp=%h", c, b_taddr, 32'h100 + 32'(((c - 1) / 3) % 4));
                end
            end
            if (c == 14) b_req = 4'h0;
        end
    endtask

    task automatic test_late_request();
        logic [1:0] e;
        @(negedge clk);
        a_req = 2'b10;
        a_wr  = 2'b00;
        a_addr  = {32'h0000_0008, 32'h0000_0020};
        a_wdata = {32'h0, 32'h0000_CAFE};
        a_rd_val = 32'hA5A5_0001;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            e = (c == 4) ? 2'b10 : ((c == 7) ? 2'b01 : 2'b00);
            checks++;
            if (a_ack !== e) begin
                failures++;
                $display("FAIL late_ack c%0d got=%b exp=%b", c, a_ack, e);
            end
            checks++;
            if (a_trd !== (c == 1) || a_twr !== (c == 6)) begin
                failures++;
                $display("FAIL late_strobe c%0d got trd=%b twr=%b exp trd=%b twr=%b", c, a_trd, a_twr, c == 1, c == 6);
            end
            if (c == 6) begin
                checks++;
                if (a_taddr !== 32'h20 || a_twdata !== 32'hCAFE) begin
                    failures++;
                    $display("FAIL late_target got=%h/%h exp=00000020/0000cafe", a_taddr, a_twdata);
                end
            end
            if (c >= 4) begin
                checks++;
                if (a_rdata !== 32'hA5A5_0001) begin
                    failures++;
                    $display("FAIL late_rdata c%0d got=%h exp=a5a50001", c, a_rdata);
                end
            end
            if (c == 2) begin
                a_req[0] = 1'b1;
                a_wr[0]  = 1'b1;
            end
            if (c == 4) a_req[1] = 1'b0;
            if (c == 7) a_req[0] = 1'b0;
        end
    endtask

    task automatic test_reset_mid_read();
        logic [1:0] e;
        @(negedge clk);
        a_req = 2'b10;
        a_wr  = 2'b00;
        a_addr[63:32] = 32'h0000_0030;
        a_rd_val = 32'h7777_0000;
        @(negedge clk);
        checks++;
        if (a_trd !== 1'b1) begin
            failures++;
            $display("FAIL rst_rd_issue got=%b exp=1", a_trd);
        end
        @(negedge clk);
        reset = 1'b1;
        a_req = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({a_ack, a_twr, a_trd, a_rdata, a_taddr, a_twdata} !== 100'd0) begin
            failures++;
            $display("FAIL rst_outputs got=%h exp=0", {a_ack, a_twr, a_trd, a_rdata, a_taddr, a_twdata});
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (a_ack !== 2'b00 || a_rdata !== 32'd0 || a_trd !== 1'b0) begin
                failures++;
                $display("FAIL rst_ignored got ack=%b rdata=%h trd=%b exp 00/0/0", a_ack, a_rdata, a_trd);
            end
        end
        a_req   = 2'b11;
        a_wr    = 2'b11;
        a_addr  = {32'h44, 32'h40};
        a_wdata = {32'h2222, 32'h1111};
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            e = (c == 2) ? 2'b01 : ((c == 5) ? 2'b10 : 2'b00);
            checks++;
            if (a_ack !== e) begin
                failures++;
                $display("FAIL rst_after_ack c%0d got=%b exp=%b", c, a_ack, e);
            end
            if (c == 1 || c == 4) begin
                checks++;
                if (a_twr !== 1'b1 || a_taddr !== ((c == 1) ? 32'h40 : 32'h44)) begin
                    failures++;
                    $display("FAIL rst_after_wr c%0d got twr=%b addr=%h", c, a_twr, a_taddr);
                end
            end
            if (c == 2) a_req[0] = 1'b0;
            if (c == 5) a_req[1] = 1'b0;
        end
    endtask

    task automatic test_latency_sweep();
        @(negedge clk);
        c_req = 2'b01;
        c_addr[31:0] = 32'h50;
        c_rd_val = 32'h0101_0101;
        d_req = 2'b10;
        d_addr[63:32] = 32'h60;
        d_rd_val = 32'h0F0F_1515;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                checks++;
                if (c_ack !== ((c == 3) ? 2'b01 : 2'b00) || c_rdata !== ((c >= 3) ? 32'h0101_0101 : 32'd0)) begin
                    failures++;
                    $display("FAIL lat1 c%0d got ack=%b rdata=%h", c, c_ack, c_rdata);
                end
            end
            checks++;
            if (d_ack !== ((c == 17) ? 2'b10 : 2'b00) || d_trd !== (c == 1)) begin
                failures++;
                $display("FAIL lat15_ctl c%0d got ack=%b trd=%b", c, d_ack, d_trd);
            end
            checks++;
            if (d_rdata !== ((c >= 17) ? 32'h0F0F_1515 : 32'd0)) begin
                failures++;
                $display("FAIL lat15_data c%0d got=%h exp=%h", c, d_rdata, (c >= 17) ? 32'h0F0F_1515 : 32'd0);
            end
            if (c == 3) c_req = 2'b00;
            if (c == 17) d_req = 2'b00;
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_late_request();
        test_reset_mid_read();
        test_latency_sweep();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bridge_arbiter.md
BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of requesters sharing the target (legal 2..8).
REQ-002 SHALL have parameter RD_LATENCY, default 2, cycles from t_rd strobe to valid t_rd_data (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port m_req  input  NUM_MASTERS  per-master request, held high until that master's m_ack.
REQ-006 SHALL have port m_wr  input  NUM_MASTERS  per-master op select: 1 = write, 0 = read.
REQ-007 SHALL have port m_addr  input  NUM_MASTERS*32  per-master bridge address, master i at bits [32i+31:32i].
REQ-008 SHALL have port m_wr_data  input  NUM_MASTERS*32  per-master write data, same packing.
REQ-009 SHALL have port m_ack  output  NUM_MASTERS  one-cycle completion pulse to the granted master.
REQ-010 SHALL have port m_rd_data  output  32  read data shared by all masters; valid when m_ack is high for a read.
REQ-011 SHALL have port t_addr  output  32  target bridge address.
REQ-012 SHALL have port t_wr_data  output  32  target write data.
REQ-013 SHALL have port t_wr  output  1  target write strobe, one cycle per write.
REQ-014 SHALL have port t_rd  output  1  target read strobe, one cycle per read.
REQ-015 SHALL have port t_rd_data  input  32  target read data, valid RD_LATENCY cycles after t_rd.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-017 IDLE: if any m_req bit high, SHALL select winner by round-robin starting at priority pointer, latch winner index, m_wr, m_addr, m_wr_data, go ISSUE; else stay IDLE.
REQ-018 Round-robin: winner is first requesting index at or above pointer, wrapping from NUM_MASTERS-1 to 0.
REQ-019 ISSUE (exactly one cycle): SHALL drive t_addr/t_wr_data from latched values and t_wr=1 (write) or t_rd=1 (read), never both.
REQ-020 After ISSUE, write SHALL go DONE; read SHALL go WAIT with a 4-bit counter loaded so t_rd_data is sampled on the clock edge ending cycle (ISSUE cycle + RD_LATENCY).
REQ-021 WAIT: SHALL capture t_rd_data into m_rd_data at that edge and go DONE; t_wr/t_rd stay low throughout.
REQ-022 DONE (one cycle): m_ack[winner]=1, all other m_ack bits 0; pointer SHALL become (winner+1) mod NUM_MASTERS; next state IDLE.
REQ-023 Latency from m_req first high in IDLE (cycle 0): t_wr/t_rd in cycle 1; write m_ack in cycle 2; read m_ack in cycle 2+RD_LATENCY.
REQ-024 m_req SHALL be sampled only in IDLE; changes in ISSUE/WAIT/DONE SHALL not affect the current transaction; a master's m_req still high in IDLE after its ack SHALL be treated as a new request.
REQ-025 Requests arriving during a transaction SHALL wait; no request SHALL starve: with all masters requesting continuously, each is served once per NUM_MASTERS transactions.
REQ-026 t_addr and t_wr_data SHALL hold last issued values outside ISSUE; m_rd_data SHALL hold last captured read until the next read capture, unchanged by writes.
REQ-027 At most one transaction outstanding to target at any time; back-to-back transactions separated by at least one IDLE cycle.

Reset
REQ-028 On reset high at a clock edge, from any state: state=IDLE, pointer=0, m_ack=0, t_wr=0, t_rd=0, t_addr=0, t_wr_data=0, m_rd_data=0, counter=0.
REQ-029 Reset mid-transaction SHALL abandon it with no m_ack; target data returning afterward SHALL be ignored.

Verification
REQ-030 Single write: master 1 req, m_wr=1, addr 0x0000_0010, data 0xDEAD_BEEF -> cycle 1 t_wr=1 with those values, cycle 2 m_ack=2'b10, t_rd stays 0.
REQ-031 Single read, RD_LATENCY=2: master 0 reads 0x0000_0004, target model returns 0x1234_5678 two cycles after t_rd -> m_ack[0] in cycle 4 with m_rd_data=0x1234_5678.
REQ-032 Contention: NUM_MASTERS=4, all request from reset -> service order 0,1,2,3,0; exactly one m_ack bit per transaction.
REQ-033 Late request: master 0 raises m_req during WAIT of master 1's read -> master 0 served in the next IDLE, not earlier; no t_rd/t_wr during WAIT.
REQ-034 Reset mid-read: assert reset in WAIT -> next cycle all outputs zero, no m_ack, pointer 0; subsequent master 1 write completes normally.
REQ-035 RD_LATENCY=1 and 15 sweep: read data captured exactly RD_LATENCY cycles after t_rd; wrong-cycle target data never reaches m_rd_data.
